// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and frame-length helper for the serial transmit path
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } piso_state_t;

  function automatic int frame_len(input int wide, input int div, input int parity_en);
    return (wide + 2 + parity_en) * div;
  endfunction

endpackage

// File: rtl/piso_load_shreg.sv
// rtl/piso_load_shreg.sv - loadable shift register presenting one output-end bit
module piso_load_shreg #(
  parameter int WIDE      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WIDE-1:0] load_data,
  input  logic            shift,
  output logic            bit_out
);

  logic [WIDE-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      if (MSB_FIRST) sr <= {sr[WIDE-2:0], 1'b0};
      else           sr <= {1'b0, sr[WIDE-1:1]};
    end
  end

  assign bit_out = MSB_FIRST ? sr[WIDE-1] : sr[0];

endmodule

// File: rtl/piso_frame_ctrl.sv
// rtl/piso_frame_ctrl.sv - framed parallel-to-serial transmit controller (start, data, parity, stop)
module piso_frame_ctrl
  import piso_pkg::*;
#(
  parameter int WIDE      = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WIDE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            ser_out,
  output logic            ser_active,
  output logic            done
);

  localparam int TW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW       = $clog2(WIDE + 1);
  localparam int TICK_PRE = (DIV > 1) ? DIV - 2 : 0;

  piso_state_t   state;
  logic [TW-1:0] tick;
  logic [BW-1:0] bitcnt;
  logic          parity;
  logic          bit_out;
  logic          tick_last;
  logic          load;
  logic          shift;

  assign in_ready  = (state == IDLE);
  assign tick_last = (tick == TW'(DIV - 1));
  assign load      = in_ready && in_valid;
  // The register runs one bit ahead of ser_out: each bit is consumed as it is registered.
  assign shift     = tick_last && (state == START || state == DATA);

  piso_load_shreg #(
    .WIDE      (WIDE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (in_data),
    .shift     (shift),
    .bit_out   (bit_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bitcnt     <= '0;
      parity     <= 1'b0;
      ser_out    <= 1'b1;
      ser_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          state      <= START;
          tick       <= '0;
          bitcnt     <= '0;
          parity     <= ^in_data;
          ser_out    <= 1'b0;
          ser_active <= 1'b1;
        end
      end else begin
        tick <= tick_last ? '0 : tick + 1'b1;
        if (tick_last) begin
          case (state)
            START: begin
              state   <= DATA;
              ser_out <= bit_out;
            end
            DATA: begin
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == BW'(WIDE - 1)) begin
                state   <= PARITY_EN ? PAR : STOP;
                ser_out <= PARITY_EN ? parity : 1'b1;
                if (!PARITY_EN && DIV == 1) done <= 1'b1;
              end else begin
                ser_out <= bit_out;
              end
            end
            PAR: begin
              state   <= STOP;
              ser_out <= 1'b1;
              if (DIV == 1) done <= 1'b1;
            end
            default: begin
              state      <= IDLE;
              ser_out    <= 1'b1;
              ser_active <= 1'b0;
            end
          endcase
        end else if (DIV > 1 && state == STOP && tick == TW'(TICK_PRE)) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// tb/tb_piso_frame_ctrl.sv - scoreboard bench over four parameterisations of the transmit controller
module tb_piso_frame_ctrl;
  import piso_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] id  [4];
  logic       iv  [4];
  logic       rdy [4];
  logic       so  [4];
  logic       sa  [4];
  logic       dn  [4];

  int   checks = 0;
  int   failures = 0;
  logic exp_q [$];

  always #5 clk = ~clk;

  piso_frame_ctrl #(.WIDE(4), .DIV(1), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_a (
    .clk(clk), .reset(reset), .in_data(id[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .ser_out(so[0]), .ser_active(sa[0]), .done(dn[0]));
  piso_frame_ctrl #(.WIDE(4), .DIV(1), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .in_data(id[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .ser_out(so[1]), .ser_active(sa[1]), .done(dn[1]));
  piso_frame_ctrl #(.WIDE(4), .DIV(1), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_c (
    .clk(clk), .reset(reset), .in_data(id[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
    .ser_out(so[2]), .ser_active(sa[2]), .done(dn[2]));
  piso_frame_ctrl #(.WIDE(4), .DIV(3), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_d (
    .clk(clk), .reset(reset), .in_data(id[3]), .in_valid(iv[3]), .in_ready(rdy[3]),
    .ser_out(so[3]), .ser_active(sa[3]), .done(dn[3]));

  function automatic int p_div(input int i);
    return (i == 3) ? 3 : 1;
  endfunction

  function automatic bit p_msb(input int i);
    return (i != 1);
  endfunction

  function automatic int p_par(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d t=%0t observed=%0h expected=%0h", tag, idx, $time, obs, exp);
    end
  endtask

  task automatic push_lvl(input logic v, input int d);
    repeat (d) exp_q.push_back(v);
  endtask

  task automatic build(input int idx, input logic [3:0] w);
    push_lvl(1'b0, p_div(idx));
    for (int j = 0; j < 4; j++)
      push_lvl(p_msb(idx) ? w[3-j] : w[j], p_div(idx));
    if (p_par(idx) != 0) push_lvl(^w, p_div(idx));
    push_lvl(1'b1, p_div(idx));
  endtask

  // Entered at the negedge of cycle k+1; leaves at the negedge of cycle k+F.
  task automatic expect_frame(input int idx, input logic [3:0] w);
    int  n;
    logic e;
    build(idx, w);
    n = frame_len(4, p_div(idx), p_par(idx));
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      chk("ser_out", idx, 32'(so[idx]), 32'(e));
      chk("ser_active", idx, 32'(sa[idx]), 32'd1);
      chk("done", idx, 32'(dn[idx]), (i == n - 1) ? 32'd1 : 32'd0);
      chk("in_ready_busy", idx, 32'(rdy[idx]), 32'd0);
    end
    exp_q.delete();
  endtask

  task automatic chk_idle(input int idx);
    chk("idle_ready", idx, 32'(rdy[idx]), 32'd1);
    chk("idle_active", idx, 32'(sa[idx]), 32'd0);
    chk("idle_line", idx, 32'(so[idx]), 32'd1);
    chk("idle_done", idx, 32'(dn[idx]), 32'd0);
  endtask

  task automatic send(input int idx, input logic [3:0] w);
    @(negedge clk);
    chk("ready_pre", idx, 32'(rdy[idx]), 32'd1);
    iv[idx] = 1'b1;
    id[idx] = w;
    @(negedge clk);
    iv[idx] = 1'b0;
    id[idx] = ~w;
    expect_frame(idx, w);
    @(negedge clk);
    chk_idle(idx);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      id[i] = 4'h0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) chk_idle(i);

    send(0, 4'b1101);
    send(1, 4'b1101);
    send(2, 4'b1101);
    send(2, 4'b1001);
    send(3, 4'b0100);

    // Back-to-back with in_valid held high; data changed mid-frame must not leak out.
    @(negedge clk);
    iv[0] = 1'b1;
    id[0] = 4'b1010;
    @(negedge clk);
    id[0] = 4'b1001;
    expect_frame(0, 4'b1010);
    @(negedge clk);
    chk_idle(0);
    @(negedge clk);
    iv[0] = 1'b0;
    id[0] = 4'b0110;
    expect_frame(0, 4'b1001);
    @(negedge clk);
    chk_idle(0);

    // Reset during the second data bit; an accept coinciding with reset is dropped.
    @(negedge clk);
    iv[0] = 1'b1;
    id[0] = 4'b1101;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("rst_start", 0, 32'(so[0]), 32'd0);
    @(negedge clk);
    chk("rst_bit0", 0, 32'(so[0]), 32'd1);
    @(negedge clk);
    chk("rst_bit1", 0, 32'(so[0]), 32'd1);
    reset = 1'b1;
    iv[1] = 1'b1;
    id[1] = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    iv[1] = 1'b0;
    chk_idle(0);
    chk("rst_accept_dropped", 1, 32'(sa[1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_done", 0, 32'(dn[0]), 32'd0);
      chk("rst_quiet_b", 1, 32'(sa[1]), 32'd0);
    end
    send(0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_frame_ctrl.md
# piso_frame_ctrl

Transmit-side controller for the team's parallel-in/serial-out shift path. It accepts one WIDE-bit word per valid/ready handshake, loads it into a shift register, and sequences a framed serial stream: start bit, WIDE data bits, optional even parity, stop bit. Bit period is programmable in clock cycles. It sits between a parallel producer and a single-wire serial sink, and it owns all load/shift sequencing.

## Interface
- WIDE, 4, data word width in bits (≥2)
- DIV, 1, clock cycles per serial bit (≥1)
- MSB_FIRST, 1, 1 = data bit WIDE-1 sent first; 0 = bit 0 sent first
- PARITY_EN, 0, 1 = insert an even-parity bit after the data bits
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDE  parallel word; sampled on accept
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept; accept = in_valid & in_ready at a clk edge
- ser_out  out  1  serial line; idles high
- ser_active  out  1  high for every cycle of a frame (start through stop)
- done  out  1  one-cycle pulse on the final cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: in_ready=1, ser_out=1, ser_active=0. On accept, load in_data into the shift register, clear the tick and bit counters, and go to START.
- START: ser_out=0 for DIV cycles, then go to DATA.
- DATA: ser_out = current shift-register output bit. Each bit holds for DIV cycles. At the end of each bit, shift toward the output end and increment the bit counter. After WIDE bits, go to PAR if PARITY_EN, else to STOP.
- PAR: ser_out = XOR of all loaded data bits for DIV cycles. Parity is computed from the loaded word, not from the shifting copy. Then go to STOP.
- STOP: ser_out=1 for DIV cycles. done=1 on the last of these cycles. Then go to IDLE.
- in_ready is high only in IDLE. in_valid outside IDLE is ignored, and in_data is not sampled. The word need not be held after accept.
- in_data changes while in_valid is low, or after accept, have no effect.
- Reset has priority over everything. The cycle after an edge with reset=1 gives state=IDLE, ser_out=1, ser_active=0, done=0, in_ready=1, counters=0, shift register=0. An accept coinciding with reset is discarded.
- Reset mid-frame aborts the frame: no done pulse, and the line returns high the next cycle.
- ser_out, ser_active and done are registered outputs. in_ready is decoded from the state register.

## Timing
- Frame length F = (WIDE + 2 + PARITY_EN) × DIV cycles.
- Accept at edge k: ser_out=0 and ser_active=1 from cycle k+1. The first data bit appears at cycle k+1+DIV.
- done is high in cycle k+F. in_ready returns high at cycle k+F+1.
- Minimum accept-to-accept spacing is F+1 cycles. There is no overlap of a new word with STOP.
- Tick counter width is clog2(DIV) bits, with a minimum of 1. When DIV=1, every cycle is a bit boundary. The counter wraps to 0 at DIV-1.
- Bit counter width is clog2(WIDE+1). It is compared against WIDE-1 at each bit boundary; it never wraps.

## Structure
- Shared package piso_pkg holds:
  - the state typedef, encoded IDLE=0, START=1, DATA=2, PAR=3, STOP=4;
  - a frame-length function of WIDE, DIV and PARITY_EN, used by the RTL and by the bench.
- One sub-module, piso_load_shreg: WIDE-bit shift register with parameter MSB_FIRST and ports clk, reset, load, load_data, shift, bit_out.
  - load has priority over shift.
  - bit_out is the current output-end bit.
- The FSM, tick counter, bit counter and parity register live in piso_frame_ctrl.

## Test plan
- WIDE=4, DIV=1, MSB_FIRST=1: accept 4'b1101 → ser_out = 0,1,1,0,1,1 over cycles k+1..k+6; done at k+6; in_ready at k+7.
- MSB_FIRST=0, same word → ser_out = 0,1,0,1,1,1; ser_active high for exactly 6 cycles.
- PARITY_EN=1: 4'b1101 → 0,1,1,0,1,1,1 (parity=1); 4'b1001 → 0,1,0,0,1,0,1 (parity=0); done at k+7.
- DIV=3: 4'b0100 → each level held 3 cycles; 18-cycle frame; done at k+18.
- Back-to-back: in_valid held high with 4'b1010 then 4'b1001 → second accept exactly F+1 cycles after the first; in_data changes mid-frame do not alter ser_out.
- Reset asserted during the second DATA bit → next cycle ser_out=1, in_ready=1, ser_active=0; no done. A subsequent accept of 4'b0000 sends 0,0,0,0,0,1.
